router_out_port: RTL and testbench

Per-port output drain engine for the 1x3 router. It sits between one `router_fifo` read side and the destination client. It pops bytes from the FIFO and frames them into packets: header, payload, then parity. It presents the packets on a valid/ready stream, checks parity, and produces the FIFO `soft_reset` when the client stops reading for too long.

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_out_skid.sv | 83 ++++++++
 rtl/router_out_port.sv | 143 ++++++++++++++
 tb/tb_router_out_port.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header field layout for the router output port.
package router_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 30;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned LEN_MSB         = 7;
    localparam int unsigned LEN_LSB         = 2;
    localparam int unsigned DEST_MSB        = 1;
    localparam int unsigned LEN_W           = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned DEST_W          = DEST_MSB + 1;
    localparam int unsigned STALL_W         = 5;
    localparam int unsigned OCC_W           = 2;

    typedef enum logic [1:0] {
        HDR = 2'd0,
        PAY = 2'd1,
        PAR = 2'd2
    } frame_state_e;

    // One framed output byte as it sits in the output buffer.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              err;
        logic [DEST_W-1:0] dest;
    } beat_t;

endpackage

// File: rtl/router_out_skid.sv
// Two-entry output buffer; the head entry is a plain register so the
// stream outputs come straight from flops.
module router_out_skid
    import router_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  beat_t            i_entry,
    input  logic             i_pop,
    output beat_t            o_head,
    output logic             o_valid,
    output logic [OCC_W-1:0] o_occ
);

    beat_t            r_head;
    beat_t            r_tail;
    beat_t            w_head_nxt;
    beat_t            w_tail_nxt;
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_nxt;
    logic             r_valid;
    logic             w_pop;

    // Vacated slots are zeroed so outputs read 0 whenever nothing is valid.
    always_comb begin
        w_pop      = i_pop && (r_occ != '0);
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        w_occ_nxt  = r_occ;
        if (i_flush) begin
            w_head_nxt = '0;
            w_tail_nxt = '0;
            w_occ_nxt  = '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == '0) begin
                        w_head_nxt = i_entry;
                    end else begin
                        w_tail_nxt = i_entry;
                    end
                    w_occ_nxt = r_occ + OCC_W'(1);
                end
                2'b01: begin
                    w_head_nxt = (r_occ == OCC_W'(2)) ? r_tail : '0;
                    w_tail_nxt = '0;
                    w_occ_nxt  = r_occ - OCC_W'(1);
                end
                2'b11: begin
                    if (r_occ == OCC_W'(2)) begin
                        w_head_nxt = r_tail;
                        w_tail_nxt = i_entry;
                    end else begin
                        w_head_nxt = i_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != '0);
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_occ   = r_occ;

endmodule

// File: rtl/router_out_port.sv
// Per-port output drain engine: pops FIFO bytes, frames them into
// header/payload/parity beats, and flushes the FIFO on client stall.
module router_out_port
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              soft_reset,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_err,
    output logic [DEST_W-1:0] m_dest
);

    frame_state_e       r_state;
    frame_state_e       w_state_nxt;
    logic               r_inflight;
    logic               r_soft_reset;
    logic [LEN_W-1:0]   r_rem;
    logic [DATA_W-1:0]  r_par;
    logic [DEST_W-1:0]  r_dest;
    logic [STALL_W-1:0] r_stall;
    logic               w_capture;
    logic               w_pop;
    logic               w_stalled;
    logic [LEN_W-1:0]   w_hdr_len;
    logic [OCC_W-1:0]   w_occ;
    logic               w_head_valid;
    beat_t              w_entry;
    beat_t              w_head;

    // A byte in flight during the flush cycle belongs to the flushed packet.
    assign w_capture = r_inflight && !r_soft_reset;
    assign w_hdr_len = fifo_data[LEN_MSB:LEN_LSB];
    assign w_pop     = w_head_valid && m_ready;
    assign w_stalled = w_head_valid && !m_ready;

    // Credit: buffered plus in-flight bytes never exceed the two buffer slots.
    assign fifo_rd = !fifo_empty && !r_soft_reset
                     && (({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_soft_reset) begin
            w_state_nxt = HDR;
        end else if (w_capture) begin
            case (r_state)
                HDR:     w_state_nxt = (w_hdr_len == '0) ? PAR : PAY;
                PAY:     w_state_nxt = (r_rem == LEN_W'(1)) ? PAR : PAY;
                PAR:     w_state_nxt = HDR;
                default: w_state_nxt = HDR;
            endcase
        end
    end

    always_comb begin
        w_entry      = '0;
        w_entry.data = fifo_data;
        w_entry.sop  = (r_state == HDR);
        w_entry.eop  = (r_state == PAR);
        w_entry.err  = (r_state == PAR) && (fifo_data != r_par);
        w_entry.dest = (r_state == HDR) ? fifo_data[DEST_MSB:0] : r_dest;
    end

    // Remaining payload count, running parity and latched destination.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rem  <= '0;
            r_par  <= '0;
            r_dest <= '0;
        end else if (w_capture) begin
            case (r_state)
                HDR: begin
                    r_rem  <= w_hdr_len;
                    r_par  <= fifo_data;
                    r_dest <= fifo_data[DEST_MSB:0];
                end
                PAY: begin
                    r_rem <= r_rem - LEN_W'(1);
                    r_par <= r_par ^ fifo_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Read tracking and stall timeout; the pulse lands on the cycle after
    // the counter reaches TIMEOUT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight   <= 1'b0;
            r_soft_reset <= 1'b0;
            r_stall      <= '0;
        end else begin
            r_inflight   <= fifo_rd;
            r_soft_reset <= !r_soft_reset && w_stalled
                            && (r_stall == STALL_W'(TIMEOUT - 1));
            if (r_soft_reset || !w_stalled) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + STALL_W'(1);
            end
        end
    end

    router_out_skid u_skid (
        .i_clock (clock),
        .i_reset (reset),
        .i_flush (r_soft_reset),
        .i_push  (w_capture),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_head_valid),
        .o_occ   (w_occ)
    );

    assign soft_reset = r_soft_reset;
    assign m_valid    = w_head_valid;
    assign m_data     = w_head.data;
    assign m_sop      = w_head.sop;
    assign m_eop      = w_head.eop;
    assign m_err      = w_head.err;
    assign m_dest     = w_head.dest;

endmodule

// File: tb/tb_router_out_port.sv
// Randomized bench for router_out_port against a packet-level reference model.
module tb_router_out_port;

    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       soft_reset;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sop;
    logic       m_eop;
    logic       m_err;
    logic [1:0] m_dest;

    router_out_port #(.TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .soft_reset (soft_reset),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .m_err      (m_err),
        .m_dest     (m_dest)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        logic [1:0] dest;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_beats  = 0;
    int sr_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, got, exp, $time);
    endtask

    // FIFO model: registered read data, flushed by reset and soft_reset.
    logic [7:0] fmem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int outstanding = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr      <= wr_ptr;
            fifo_data   <= 8'hzz;
            outstanding <= 0;
        end else if (soft_reset) begin
            rd_ptr      <= wr_ptr;
            fifo_data   <= 8'hzz;
            outstanding <= 0;
        end else begin
            if (fifo_rd && !fifo_empty) begin
                fifo_data <= fmem[rd_ptr % 4096];
                rd_ptr    <= rd_ptr + 1;
            end else begin
                fifo_data <= 8'hzz;
            end
            outstanding <= outstanding + (fifo_rd ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fmem[wr_ptr % 4096] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Whole-packet reference: expected beats follow from header, payload and parity.
    task automatic push_raw(input logic [7:0] hdr, input logic [7:0] pay[$], input logic [7:0] parity);
        logic [7:0] acc;
        acc = hdr;
        push_byte(hdr);
        exp_q.push_back(exp_t'{hdr, 1'b1, 1'b0, 1'b0, hdr[1:0]});
        foreach (pay[i]) begin
            acc = acc ^ pay[i];
            push_byte(pay[i]);
            exp_q.push_back(exp_t'{pay[i], 1'b0, 1'b0, 1'b0, hdr[1:0]});
        end
        push_byte(parity);
        exp_q.push_back(exp_t'{parity, 1'b0, 1'b1, (parity != acc), hdr[1:0]});
    endtask

    task automatic push_pkt(input logic [5:0] len, input logic [1:0] dest, input bit bad);
        logic [7:0] pay[$];
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = {len, dest};
        par = hdr;
        for (int i = 0; i < int'(len); i++) begin
            pay.push_back(8'($urandom));
            par = par ^ pay[i];
        end
        if (bad) par = par ^ 8'($urandom_range(1, 255));
        push_raw(hdr, pay, par);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Client ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 never.
    int ready_mode = 0;
    int rphase = 0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (rphase == 0 || rphase == 3);
                    rphase = (rphase + 1) % 4;
                end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: beat order/content, stall stability, timeout and credit bound.
    int stall_run = 0;
    bit prev_stall = 0;
    bit prev_sr = 0;
    logic [7:0] prev_data;
    logic prev_sop, prev_eop;
    logic [1:0] prev_dest;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_run  = 0;
                prev_stall = 0;
                prev_sr    = 0;
            end else begin
                check("soft_reset", 32'(soft_reset), 32'(stall_run == TIMEOUT));
                check("credit_bound", 32'(outstanding <= 2), 32'd1);
                if (prev_sr) check("flush_valid", 32'(m_valid), 32'd0);
                if (soft_reset) check("flush_rd", 32'(fifo_rd), 32'd0);
                if (prev_stall && m_valid) begin
                    check("stall_data", 32'(m_data), 32'(prev_data));
                    check("stall_sop", 32'(m_sop), 32'(prev_sop));
                    check("stall_eop", 32'(m_eop), 32'(prev_eop));
                    check("stall_dest", 32'(m_dest), 32'(prev_dest));
                end
                if (m_valid && m_ready) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(m_data), 32'(e.data));
                        check("beat_sop", 32'(m_sop), 32'(e.sop));
                        check("beat_eop", 32'(m_eop), 32'(e.eop));
                        check("beat_dest", 32'(m_dest), 32'(e.dest));
                        if (e.eop) check("beat_err", 32'(m_err), 32'(e.err));
                    end
                end
                if (soft_reset) begin
                    sr_pulses++;
                    exp_q.delete();
                    stall_run = 0;
                end else if (m_valid && !m_ready) begin
                    stall_run++;
                end else begin
                    stall_run = 0;
                end
                prev_stall = m_valid && !m_ready && !soft_reset;
                prev_sr    = soft_reset;
                prev_data  = m_data;
                prev_sop   = m_sop;
                prev_eop   = m_eop;
                prev_dest  = m_dest;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] pay[$];
        int b0;
        int s0;
        int n;

        reset = 1'b1;
        #12;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_sop", 32'(m_sop), 32'd0);
        check("rst_eop", 32'(m_eop), 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_dest", 32'(m_dest), 32'd0);
        check("rst_soft", 32'(soft_reset), 32'd0);
        check("rst_rd", 32'(fifo_rd), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed single packet, good parity, then bad parity.
        ready_mode = 0;
        @(negedge clock);
        pay.delete();
        pay.push_back(8'h11);
        pay.push_back(8'h22);
        pay.push_back(8'h33);
        b0 = n_beats;
        push_raw(8'h0D, pay, 8'h0D);
        wait_drain(200, "drain_single");
        check("single_beats", 32'(n_beats - b0), 32'd5);
        push_raw(8'h0D, pay, 8'h2F);
        wait_drain(200, "drain_badpar");

        // Zero-length packet.
        pay.delete();
        b0 = n_beats;
        push_raw(8'h02, pay, 8'h02);
        wait_drain(200, "drain_zero");
        check("zero_beats", 32'(n_beats - b0), 32'd2);

        // Maximum length and back-pressure pattern.
        push_pkt(6'd63, 2'd0, 1'b0);
        wait_drain(1000, "drain_maxlen");
        ready_mode = 1;
        b0 = n_beats;
        push_pkt(6'd8, 2'd3, 1'b0);
        wait_drain(500, "drain_bp");
        check("bp_beats", 32'(n_beats - b0), 32'd10);

        // Randomized batches under varying client readiness.
        for (int batch = 0; batch < 6; batch++) begin
            ready_mode = batch % 3;
            for (int k = 0; k < 5; k++) begin
                push_pkt(($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom_range(0, 63)),
                         2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            end
            wait_drain(4000, "drain_rand");
        end

        // Timeout: client never ready.
        ready_mode = 3;
        @(negedge clock);
        s0 = sr_pulses;
        push_pkt(6'd5, 2'd3, 1'b0);
        n = 0;
        while (!soft_reset && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("timeout_seen", 32'(soft_reset), 32'd1);
        repeat (40) @(negedge clock);
        check("timeout_once", 32'(sr_pulses - s0), 32'd1);
        check("timeout_idle", 32'(m_valid), 32'd0);
        ready_mode = 0;
        @(negedge clock);
        push_pkt(6'd2, 2'd1, 1'b0);
        wait_drain(200, "drain_after_to");

        // Asynchronous reset mid-payload.
        b0 = n_beats;
        push_pkt(6'd40, 2'd1, 1'b0);
        n = 0;
        while ((n_beats - b0) < 5 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("pre_reset_beats", 32'(n_beats - b0 >= 5), 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", 32'(m_valid), 32'd0);
        check("areset_data", 32'(m_data), 32'd0);
        check("areset_sop", 32'(m_sop), 32'd0);
        check("areset_eop", 32'(m_eop), 32'd0);
        check("areset_err", 32'(m_err), 32'd0);
        check("areset_dest", 32'(m_dest), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        b0 = n_beats;
        push_pkt(6'd4, 2'd2, 1'b0);
        wait_drain(200, "drain_after_rst");
        check("post_reset_beats", 32'(n_beats - b0), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
